ordering_unloader: RTL and testbench
====================================

ORDERING_UNLOADER -- requirements
Module: ordering_unloader

Interface
REQ-001 SHALL have parameter REPLICA_NUM, default 32, number of replicas per unload sweep.
REQ-002 SHALL have parameter CITY_NUM, default 100, valid city count; city indices 0..CITY_NUM-1.
REQ-003 SHALL have parameter BEATS, default 13, beats per replica (8 city slots per beat; slots >= CITY_NUM are padding).
REQ-004 SHALL have parameter TOTAL_W, default 27, width of the total-distance field.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  arm/re-arm a capture sweep.
REQ-008 ordering_out_valid  input  1  one ordering beat present.
REQ-009 ordering_out_data  input  8x8  beat payload; slot j of the beat in byte lane 7-j, bits [6:0] = city, bit 7 ignored.
REQ-010 total_out_data  input  TOTAL_W  total distance of the replica whose first beat is present.
REQ-011 rd_addr  input  clog2(REPLICA_NUM*BEATS)  host beat-word read address (replica*BEATS+beat).
REQ-012 rd_data  output  64  registered beat word, stored exactly as received.
REQ-013 tot_addr  input  clog2(REPLICA_NUM)  host total read address.
REQ-014 tot_data  output  TOTAL_W  registered captured total.
REQ-015 busy  output  1  high in CAPTURE.
REQ-016 done  output  1  high in DONE.
REQ-017 perm_err  output  REPLICA_NUM  per-replica sticky ordering error.
REQ-018 overflow  output  1  sticky: beat received outside CAPTURE.

Function
REQ-019 SHALL implement states IDLE, CAPTURE, DONE.
REQ-020 IDLE/DONE + start -> CAPTURE next cycle; clears replica counter, beat counter, seen vector, perm_err, overflow.
REQ-021 start in CAPTURE SHALL restart identically to REQ-020; any beat in the start cycle is discarded, not counted, not flagged.
REQ-022 In CAPTURE, each valid beat SHALL write ordering_out_data to buffer word replica*BEATS+beat; beat counter +1.
REQ-023 On beat 0 of each replica, total_out_data SHALL be stored to total slot [replica].
REQ-024 Beat counter SHALL wrap BEATS-1 -> 0 and advance replica counter; seen vector (CITY_NUM bits) cleared at that wrap.
REQ-025 After beat BEATS-1 of replica REPLICA_NUM-1, state SHALL go CAPTURE -> DONE next cycle; done stays high until start or reset.
REQ-026 Per beat, for each slot s=8*beat+j with s < CITY_NUM: city >= CITY_NUM or city already seen (including duplicate within the same beat) SHALL set perm_err[replica]; otherwise mark seen.
REQ-027 Padding slots (s >= CITY_NUM) SHALL be stored but never checked.
REQ-028 At the wrap of REQ-024, if any seen bit is 0, perm_err[replica] SHALL be set.
REQ-029 valid in IDLE or DONE SHALL set overflow and SHALL not write buffer.
REQ-030 Beats with valid low SHALL change nothing; gaps of any length allowed.
REQ-031 rd_data/tot_data SHALL reflect the addressed entry one cycle after rd_addr/tot_addr; a read of an entry written in the same cycle returns old data.
REQ-032 Read addresses beyond REPLICA_NUM*BEATS-1 SHALL return 0.

Reset
REQ-033 reset SHALL force IDLE; busy=0, done=0, perm_err=0, overflow=0, rd_data=0, tot_data=0, counters and seen vector 0.
REQ-034 reset mid-CAPTURE SHALL abort the sweep; buffer and total contents are not cleared and remain readable.
REQ-035 reset SHALL take priority over start and valid in the same cycle.

Verification
REQ-036 start, then 416 beats of identity order (replica r totals = 1000+r) -> done=1 the cycle after beat 415, perm_err=0, overflow=0, tot_addr=5 gives 1005, rd_addr=0 gives byte lane 7 = 0, lane 0 = 7.
REQ-037 Replica 3 beat 2 slot 4 duplicated with city 1 -> perm_err=0x00000008, all other bits 0, done still after 416 beats.
REQ-038 Replica 0 slot 50 = city 120 -> perm_err[0]=1; padding slot 101 = 120 in replica 1 -> perm_err[1]=0.
REQ-039 Valid beat in IDLE -> overflow=1, rd_data at word 0 unchanged; start then clears overflow.
REQ-040 Sweep with random valid gaps, start reasserted after 200 beats -> counters restart, done only after 416 further beats.
REQ-041 reset after 100 beats -> busy=0, done=0, perm_err=0; rd_addr=50 still returns beat 50 payload.

Source files
------------

// File: rtl/ordering_unloader_if.sv
// Ordering stream from the solver core: one 8-slot beat per valid cycle,
// with the replica total presented alongside its first beat.
interface ordering_unloader_if #(
    parameter int TOTAL_W = 27
);
    logic               ordering_out_valid;
    logic [7:0][7:0]    ordering_out_data;
    logic [TOTAL_W-1:0] total_out_data;

    modport master (
        output ordering_out_valid,
        output ordering_out_data,
        output total_out_data
    );

    modport slave (
        input ordering_out_valid,
        input ordering_out_data,
        input total_out_data
    );
endinterface

// File: rtl/ordering_unloader.sv
// Captures one sweep of replica orderings into a host-readable buffer,
// checking each replica's ordering is a permutation of 0..CITY_NUM-1.
module ordering_unloader #(
    parameter int REPLICA_NUM = 32,
    parameter int CITY_NUM    = 100,
    parameter int BEATS       = 13,
    parameter int TOTAL_W     = 27,
    localparam int DEPTH      = REPLICA_NUM * BEATS,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int TADDR_W    = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1,
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    ordering_unloader_if.slave     ord,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [63:0]            rd_data,
    input  logic [TADDR_W-1:0]     tot_addr,
    output logic [TOTAL_W-1:0]     tot_data,
    output logic                   busy,
    output logic                   done,
    output logic [REPLICA_NUM-1:0] perm_err,
    output logic                   overflow
);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e                 state_q, state_d;
    logic [TADDR_W-1:0]     replica_q, replica_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [CITY_NUM-1:0]    seen_q, seen_d;
    logic [REPLICA_NUM-1:0] perm_err_q, perm_err_d;
    logic                   overflow_q, overflow_d;

    logic                   buf_we, tot_we;
    logic [ADDR_W-1:0]      wr_addr;
    logic [CITY_NUM-1:0]    seen_chk;
    logic                   beat_err;

    logic [63:0]            buf_mem [DEPTH];
    logic [TOTAL_W-1:0]     tot_mem [REPLICA_NUM];
    logic [63:0]            rd_data_q;
    logic [TOTAL_W-1:0]     tot_data_q;

    assign wr_addr = ADDR_W'(int'(replica_q) * BEATS + int'(beat_q));

    // Running seen set across the 8 slots so in-beat duplicates are caught.
    always_comb begin
        seen_chk = seen_q;
        beat_err = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (int'(beat_q) * 8 + j < CITY_NUM) begin
                if (int'(ord.ordering_out_data[7-j][6:0]) >= CITY_NUM) begin
                    beat_err = 1'b1;
                end else if (seen_chk[ord.ordering_out_data[7-j][6:0]]) begin
                    beat_err = 1'b1;
                end else begin
                    seen_chk[ord.ordering_out_data[7-j][6:0]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        replica_d  = replica_q;
        beat_d     = beat_q;
        seen_d     = seen_q;
        perm_err_d = perm_err_q;
        overflow_d = overflow_q;
        buf_we     = 1'b0;
        tot_we     = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StCapture;
                    replica_d  = '0;
                    beat_d     = '0;
                    seen_d     = '0;
                    perm_err_d = '0;
                    overflow_d = 1'b0;
                end else if (ord.ordering_out_valid) begin
                    overflow_d = 1'b1;
                end
            end
            StCapture: begin
                if (start) begin
                    replica_d  = '0;
                    beat_d     = '0;
                    seen_d     = '0;
                    perm_err_d = '0;
                    overflow_d = 1'b0;
                end else if (ord.ordering_out_valid) begin
                    buf_we = 1'b1;
                    tot_we = (beat_q == '0);
                    if (beat_err) begin
                        perm_err_d[replica_q] = 1'b1;
                    end
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        if (!(&seen_chk)) begin
                            perm_err_d[replica_q] = 1'b1;
                        end
                        beat_d = '0;
                        seen_d = '0;
                        if (replica_q == TADDR_W'(REPLICA_NUM - 1)) begin
                            replica_d = '0;
                            state_d   = StDone;
                        end else begin
                            replica_d = replica_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                        seen_d = seen_chk;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset wins over any capture write in the same cycle.
        if (reset) begin
            buf_we = 1'b0;
            tot_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            replica_q  <= '0;
            beat_q     <= '0;
            seen_q     <= '0;
            perm_err_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            replica_q  <= replica_d;
            beat_q     <= beat_d;
            seen_q     <= seen_d;
            perm_err_q <= perm_err_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset so an aborted sweep stays readable.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_addr] <= ord.ordering_out_data;
        end
        if (tot_we) begin
            tot_mem[replica_q] <= ord.total_out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            tot_data_q <= '0;
        end else begin
            rd_data_q  <= (int'(rd_addr) < DEPTH) ? buf_mem[rd_addr] : '0;
            tot_data_q <= (int'(tot_addr) < REPLICA_NUM) ? tot_mem[tot_addr] : '0;
        end
    end

    assign rd_data  = rd_data_q;
    assign tot_data = tot_data_q;
    assign busy     = (state_q == StCapture);
    assign done     = (state_q == StDone);
    assign perm_err = perm_err_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ordering_unloader.sv
// Scoreboard bench for ordering_unloader: directed sweeps with planted
// ordering faults, restarts, resets and host readback.
module tb_ordering_unloader;

    localparam int REPLICA_NUM = 32;
    localparam int CITY_NUM    = 100;
    localparam int BEATS       = 13;
    localparam int TOTAL_W     = 27;
    localparam int DEPTH       = REPLICA_NUM * BEATS;

    localparam int ModeFlip  = 1;
    localparam int ModeDup   = 2;
    localparam int ModeRange = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [8:0]         rd_addr = '0;
    logic [63:0]        rd_data;
    logic [4:0]         tot_addr = '0;
    logic [TOTAL_W-1:0] tot_data;
    logic               busy, done, overflow;
    logic [31:0]        perm_err;

    ordering_unloader_if #(.TOTAL_W(TOTAL_W)) ord_if ();

    ordering_unloader #(
        .REPLICA_NUM(REPLICA_NUM),
        .CITY_NUM   (CITY_NUM),
        .BEATS      (BEATS),
        .TOTAL_W    (TOTAL_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ord     (ord_if),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tot_addr(tot_addr),
        .tot_data(tot_data),
        .busy    (busy),
        .done    (done),
        .perm_err(perm_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
        bit          is_tot;
    } sb_t;

    sb_t         sb_q[$];
    logic [63:0] model_buf [DEPTH];
    logic [63:0] model_tot [REPLICA_NUM];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_depth", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, e.is_tot ? 64'(tot_data) : rd_data, e.exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int r, input int b, input int mode);
        logic [7:0][7:0] w;
        int s, c;
        for (int j = 0; j < 8; j++) begin
            s = 8 * b + j;
            c = s;
            if (s < CITY_NUM && (mode & ModeFlip) != 0) c = CITY_NUM - 1 - s;
            if ((mode & ModeDup) != 0 && r == 3 && b == 2 && j == 4) c = 1;
            if ((mode & ModeRange) != 0 && r == 0 && s == 50) c = 120;
            if ((mode & ModeRange) != 0 && r == 1 && s == 101) c = 120;
            // Bit 7 toggles on odd beats; the checker must ignore it.
            w[7-j] = {1'(b & 1), 7'(c)};
        end
        return w;
    endfunction

    task automatic read_word(input int addr);
        sb_t e;
        rd_addr = 9'(addr);
        e.tag = $sformatf("rd_word_%0d", addr);
        e.exp = (addr < DEPTH) ? model_buf[addr] : 64'd0;
        e.is_tot = 1'b0;
        sb_q.push_back(e);
        tick();
        sb_pop_check();
    endtask

    task automatic read_tot(input int addr);
        sb_t e;
        tot_addr = 5'(addr);
        e.tag = $sformatf("rd_tot_%0d", addr);
        e.exp = model_tot[addr];
        e.is_tot = 1'b1;
        sb_q.push_back(e);
        tick();
        sb_pop_check();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives n beats from word 0 of a sweep already started; probe_idx reads
    // the word being written in that same cycle, expecting the old contents.
    task automatic run_beats(input int n, input int mode, input int gap_max, input int probe_idx);
        sb_t e;
        int  r, b;
        for (int idx = 0; idx < n; idx++) begin
            r = idx / BEATS;
            b = idx % BEATS;
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) tick();
            end
            if (idx == DEPTH - 1) begin
                check("busy_before_last", 64'(busy), 64'd1);
                check("done_before_last", 64'(done), 64'd0);
            end
            if (idx == probe_idx) begin
                rd_addr = 9'(idx);
                e.tag = "rd_same_cycle_old";
                e.exp = model_buf[idx];
                e.is_tot = 1'b0;
                sb_q.push_back(e);
            end
            ord_if.ordering_out_data = beat_data(r, b, mode);
            ord_if.total_out_data = TOTAL_W'(((mode & ModeFlip) != 0 ? 2000 : 1000) + r);
            ord_if.ordering_out_valid = 1'b1;
            model_buf[idx] = ord_if.ordering_out_data;
            if (b == 0) model_tot[r] = 64'(ord_if.total_out_data);
            tick();
            ord_if.ordering_out_valid = 1'b0;
            if (idx == probe_idx) sb_pop_check();
        end
    endtask

    task automatic check_status(input string tag, input logic exp_busy, input logic exp_done,
                                input logic [31:0] exp_perm, input logic exp_ovf);
        check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_perm"}, 64'(perm_err), 64'(exp_perm));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        ord_if.ordering_out_valid = 1'b0;
        ord_if.ordering_out_data = '0;
        ord_if.total_out_data = '0;
        for (int i = 0; i < DEPTH; i++) model_buf[i] = '0;
        for (int i = 0; i < REPLICA_NUM; i++) model_tot[i] = '0;

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_status("reset", 1'b0, 1'b0, 32'd0, 1'b0);
        check("reset_rd_data", rd_data, 64'd0);
        check("reset_tot_data", 64'(tot_data), 64'd0);

        // Clean identity sweep.
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        run_beats(DEPTH, 0, 0, -1);
        check_status("identity", 1'b0, 1'b1, 32'd0, 1'b0);
        read_tot(5);
        check("tot5_value", 64'(tot_data), 64'd1005);
        read_tot(0);
        read_tot(31);
        read_word(0);
        check("word0_lane7", 64'(rd_data[63:56]), 64'd0);
        check("word0_lane0", 64'(rd_data[7:0]), 64'd7);
        read_word(DEPTH - 1);
        read_word(DEPTH);
        read_word(511);

        // Reset beats start and valid in the same cycle; then a beat in IDLE.
        reset = 1'b1;
        start = 1'b1;
        ord_if.ordering_out_valid = 1'b1;
        ord_if.ordering_out_data = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_status("rst_prio", 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        ord_if.ordering_out_valid = 1'b0;
        check_status("idle_beat", 1'b0, 1'b0, 32'd0, 1'b1);
        read_word(0);
        read_tot(0);
        pulse_start();
        check_status("start_clr", 1'b1, 1'b0, 32'd0, 1'b0);

        // In-beat duplicate in replica 3.
        run_beats(DEPTH, ModeDup, 0, -1);
        check_status("dup", 1'b0, 1'b1, 32'h0000_0008, 1'b0);

        // Out-of-range city in replica 0; padding abuse in replica 1 is legal.
        pulse_start();
        run_beats(DEPTH, ModeRange, 0, -1);
        check_status("range", 1'b0, 1'b1, 32'h0000_0001, 1'b0);

        // Beat in DONE is an overflow, not a write.
        ord_if.ordering_out_valid = 1'b1;
        ord_if.ordering_out_data = 64'h0123_4567_89AB_CDEF;
        tick();
        ord_if.ordering_out_valid = 1'b0;
        check_status("done_beat", 1'b0, 1'b1, 32'h0000_0001, 1'b1);
        read_word(0);

        // Restart mid-sweep with gaps; the beat in the start cycle is dropped.
        pulse_start();
        run_beats(200, 0, 3, -1);
        check("mid_busy", 64'(busy), 64'd1);
        start = 1'b1;
        ord_if.ordering_out_valid = 1'b1;
        ord_if.ordering_out_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        start = 1'b0;
        ord_if.ordering_out_valid = 1'b0;
        check_status("restart", 1'b1, 1'b0, 32'd0, 1'b0);
        run_beats(DEPTH, 0, 3, -1);
        check_status("gapped", 1'b0, 1'b1, 32'd0, 1'b0);
        read_word(200);

        // Partial reversed sweep aborted by reset; data written so far persists.
        pulse_start();
        run_beats(100, ModeFlip | ModeRange, 0, 10);
        check_status("partial", 1'b1, 1'b0, 32'h0000_0001, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_status("abort", 1'b0, 1'b0, 32'd0, 1'b0);
        read_word(50);
        read_word(99);
        read_word(100);
        read_tot(3);
        check("tot3_value", 64'(tot_data), 64'd2003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
